vmem_arbiter: RTL and testbench
===============================

Name: vmem_arbiter

Overview:
- Shares one single-port video memory between the VGA pixel-fetch path and a write client, such as the keyboard/text engine or a CPU store path.
- VGA reads have absolute priority.
- Writes are buffered in an internal FIFO and drained on cycles without a read.
- An on-demand clear sequencer fills the whole memory with a constant, using only idle cycles.

Parameters:
AW, 19, memory address width (2^AW words)
DW, 24, data width (RGB888)
FIFO_DEPTH, 4, write FIFO entries; power of 2, >=2
CLR_VALUE, 24'h000000, word written by clear sequencer

Ports:
clk  in  1  system clock, all logic on posedge
resetn  in  1  synchronous active-low reset
rd_req  in  1  VGA fetch request this cycle
rd_addr  in  AW  VGA fetch address
rd_valid  out  1  rd_data valid (rd_req delayed 1 cycle)
rd_data  out  DW  fetched word
wr_valid  in  1  write client offers a word
wr_ready  out  1  arbiter accepts the word
wr_addr  in  AW  write address
wr_data  in  DW  write data
clr_start  in  1  1-cycle pulse: begin full-memory clear
clr_busy  out  1  clear pending or in progress
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, 1-cycle synchronous read latency

Behaviour:
- Reset (resetn=0 at posedge), in any state including mid-clear:
  - FIFO emptied, fifo_level=0.
  - FSM goes to S_IDLE, clear address goes to 0.
  - rd_valid=0, clr_busy=0.
  - wr_ready=0 during the reset cycle, 1 afterwards.
- mem_* are combinational from rd_req, rd_addr, FSM state and FIFO head.
  - Memory samples them at the posedge.
  - When mem_en=0, mem_we=0 and addr/wdata are don't-care.
- Per-cycle priority:
  1. rd_req=1: mem_en=1, mem_we=0, mem_addr=rd_addr. No write occurs, FIFO does not pop, clear address does not advance.
  2. Otherwise, state S_CLEAR: write CLR_VALUE to the clear address, then the clear address increments.
  3. Otherwise, FIFO non-empty (S_IDLE or S_DRAIN): write the FIFO head, then pop.
  4. Otherwise mem_en=0.
- Read path:
  - rd_valid <= rd_req, registered.
  - rd_data = mem_rdata, passed through.
  - Latency is exactly 1 cycle, independent of write traffic.
- Write path:
  - wr_ready = (state==S_IDLE) && (fifo_level<FIFO_DEPTH).
  - A push happens on wr_valid && wr_ready.
  - Push and pop may occur in the same cycle; fifo_level is then unchanged.
  - When full, wr_ready=0 even if a pop occurs that cycle (no same-cycle pass-through).
  - Writes reach memory in acceptance order.
  - No read-after-write forwarding: a read to an address with a pending FIFO entry returns the old memory value.
- FSM states:
  - S_IDLE:
    - On clr_start: go to S_DRAIN if FIFO non-empty, else S_CLEAR.
    - No push is accepted in the clr_start cycle, because wr_ready drops combinationally? No: wr_ready still reads S_IDLE that cycle, so a push in the same cycle is accepted and drained before the clear.
  - S_DRAIN: pop FIFO on non-read cycles. Go to S_CLEAR when fifo_level reaches 0 (the final pop included).
  - S_CLEAR:
    - Clear address starts at 0.
    - After writing address 2^AW-1, go to S_IDLE and reset the clear address to 0.
    - Wrap-around is the terminal condition; no address is written twice.
- clr_busy = (state != S_IDLE).
- clr_start is ignored when state != S_IDLE.
- Continuous rd_req=1 stalls writes and clear indefinitely. This is by design: VGA blanking intervals guarantee drain time.

Test Plan:
- Reset, then rd_req=1 with rd_addr=5 (mem[5]=24'hABCDEF) -> next cycle rd_valid=1, rd_data=24'hABCDEF; fifo_level=0, wr_ready=1.
- rd_req=1 held; push 4 writes (addr 1..4) -> fifo_level=4, wr_ready=0, mem_we never 1. Then rd_req=0 -> four consecutive writes to addr 1,2,3,4 in order, fifo_level returns to 0, wr_ready=1.
- FIFO at level 2, rd_req=0, push each cycle -> level holds at 2 (push+pop). Deassert wr_valid -> level falls 2→1→0.
- AW=4 build: clr_start with 2 entries pending -> clr_busy=1, wr_ready=0, 2 FIFO writes, then 16 writes of CLR_VALUE to addr 0..15, then clr_busy=0, wr_ready=1. Alternating rd_req stretches the clear to 32 cycles with reads still returning data at 1-cycle latency.
- resetn=0 during S_CLEAR at clear address 7 -> next cycle clr_busy=0, fifo_level=0, mem_en=0 (rd_req=0). A new clr_start restarts the clear at addr 0.
- clr_start pulsed again mid-clear -> ignored: clear finishes at addr 2^AW-1 exactly once.

Source files
------------

// File: rtl/vmem_arbiter_if.sv
// Client- and memory-side signals of the video memory arbiter.
// The slave modport is the arbiter; the master modport is the pixel fetch, write client and memory.
interface vmem_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 24
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output rd_valid, rd_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  rd_valid, rd_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vmem_arbiter.sv
// Single-port video memory arbiter: VGA reads win every cycle, buffered writes
// and a whole-memory clear sequencer use the remaining idle cycles.
module vmem_arbiter #(
  parameter int            AW         = 19,
  parameter int            DW         = 24,
  parameter int            FIFO_DEPTH = 4,
  parameter logic [DW-1:0] CLR_VALUE  = '0
) (
  input  logic                          clk,
  input  logic                          resetn,
  vmem_arbiter_if.slave                 bus,
  input  logic                          clr_start,
  output logic                          clr_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_CLEAR
  } state_t;

  state_t        state, state_next;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count, count_next;
  logic [AW-1:0] clr_addr, clr_addr_next;

  logic          fifo_empty;
  logic          fifo_full;
  logic          accept;
  logic          push;
  logic          pop;
  logic          rd_valid_q;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == LW'(FIFO_DEPTH));

  // Full means not ready even if this cycle pops: no same-cycle pass-through.
  assign accept     = resetn && (state == S_IDLE) && !fifo_full;
  assign push       = bus.wr_valid && accept;

  assign bus.wr_ready = accept;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = bus.mem_rdata;
  assign clr_busy     = (state != S_IDLE);
  assign fifo_level   = count;

  // Memory port priority: read, then clear, then FIFO drain; also next-state logic.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.rd_addr;
    bus.mem_wdata = fifo_data[rd_ptr];
    pop           = 1'b0;
    clr_addr_next = clr_addr;
    state_next    = state;

    if (bus.rd_req) begin
      bus.mem_en = 1'b1;
    end else if (state == S_CLEAR) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = clr_addr;
      bus.mem_wdata = CLR_VALUE;
      clr_addr_next = clr_addr + AW'(1);
    end else if (!fifo_empty) begin
      bus.mem_en   = 1'b1;
      bus.mem_we   = 1'b1;
      bus.mem_addr = fifo_addr[rd_ptr];
      pop          = 1'b1;
    end

    count_next = count + LW'(push) - LW'(pop);

    case (state)
      S_IDLE: begin
        // A push accepted alongside clr_start is drained before clearing.
        if (clr_start)
          state_next = (count_next != '0) ? S_DRAIN : S_CLEAR;
      end
      S_DRAIN: begin
        if (count_next == '0)
          state_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (!bus.rd_req && (clr_addr == '1))
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      clr_addr   <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_next;
      clr_addr   <= clr_addr_next;
      count      <= count_next;
      rd_valid_q <= bus.rd_req;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wr_addr;
      fifo_data[wr_ptr] <= bus.wr_data;
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter on a 16-word memory model with 1-cycle read latency.
module tb_vmem_arbiter;

  localparam int            AW  = 4;
  localparam int            DW  = 24;
  localparam int            FD  = 4;
  localparam logic [DW-1:0] CLR = 24'h5A5A5A;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic       clk       = 1'b0;
  logic       resetn    = 1'b0;
  logic       clr_start = 1'b0;
  logic       clr_busy;
  logic [2:0] fifo_level;

  vmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vmem_arbiter #(
    .AW(AW), .DW(DW), .FIFO_DEPTH(FD), .CLR_VALUE(CLR)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  logic          mem_loaded = 1'b0;
  wr_t           wlog [$];
  int            vec_count   = 0;
  int            miscompares = 0;

  // Memory model: preloads a known pattern, logs every write in order.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= (i == 5) ? 24'hABCDEF : 24'h100000 + 24'(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wlog.push_back({bus.mem_addr, bus.mem_wdata});
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rq, input logic [AW-1:0] ra, input logic wv,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic cs);
    bus.rd_req   = rq;
    bus.rd_addr  = ra;
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    clr_start    = cs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  mark;
    int  cycles;
    int  n;
    logic prev_rq;
    logic rq;

    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("reset_wr_ready", 32'(bus.wr_ready), 0);
    checkOutput("reset_level", 32'(fifo_level), 0);
    checkOutput("reset_busy", 32'(clr_busy), 0);
    checkOutput("reset_rd_valid", 32'(bus.rd_valid), 0);
    resetn = 1'b1;
    #1;
    checkOutput("post_reset_wr_ready", 32'(bus.wr_ready), 1);

    // Plain read with 1-cycle latency
    applyStimulus(1, 5, 0, 0, 0, 0);
    checkOutput("rd_mem_en", 32'(bus.mem_en), 1);
    checkOutput("rd_mem_we", 32'(bus.mem_we), 0);
    checkOutput("rd_mem_addr", 32'(bus.mem_addr), 5);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rd_valid", 32'(bus.rd_valid), 1);
    checkOutput("rd_data", 32'(bus.rd_data), 32'h00ABCDEF);
    checkOutput("rd_level", 32'(fifo_level), 0);
    checkOutput("rd_wr_ready", 32'(bus.wr_ready), 1);
    tick();
    checkOutput("rd_valid_drop", 32'(bus.rd_valid), 0);

    // Fill the FIFO under continuous reads, then drain in order
    mark = wlog.size();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 0, 1, 4'(k), 24'hD00000 + 24'(k), 0);
      checkOutput("fill_wr_ready", 32'(bus.wr_ready), 1);
      checkOutput("fill_mem_we", 32'(bus.mem_we), 0);
      tick();
    end
    checkOutput("fill_no_writes", 32'(wlog.size() - mark), 0);
    applyStimulus(0, 0, 1, 4'hF, 24'hEEEEEE, 0);
    checkOutput("full_level", 32'(fifo_level), 4);
    checkOutput("full_wr_ready", 32'(bus.wr_ready), 0);
    checkOutput("drain1_we", 32'(bus.mem_we), 1);
    checkOutput("drain1_addr", 32'(bus.mem_addr), 1);
    checkOutput("drain1_data", 32'(bus.mem_wdata), 32'h00D00001);
    tick();
    checkOutput("full_pop_no_push", 32'(fifo_level), 3);
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("drain_we", 32'(bus.mem_we), 1);
      checkOutput("drain_addr", 32'(bus.mem_addr), 32'(k));
      checkOutput("drain_data", 32'(bus.mem_wdata), 32'h00D00000 + 32'(k));
      tick();
    end
    checkOutput("drained_level", 32'(fifo_level), 0);
    checkOutput("drained_wr_ready", 32'(bus.wr_ready), 1);
    checkOutput("drained_count", 32'(wlog.size() - mark), 4);
    applyStimulus(1, 3, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("readback3", 32'(bus.rd_data), 32'h00D00003);

    // Simultaneous push and pop keeps the level steady
    applyStimulus(1, 0, 1, 8, 24'hD00008, 0);
    tick();
    applyStimulus(1, 0, 1, 9, 24'hD00009, 0);
    tick();
    checkOutput("pp_level_start", 32'(fifo_level), 2);
    for (int k = 10; k <= 12; k++) begin
      applyStimulus(0, 0, 1, 4'(k), 24'hD00000 + 24'(k), 0);
      checkOutput("pp_head_addr", 32'(bus.mem_addr), 32'(k - 2));
      tick();
      checkOutput("pp_level_hold", 32'(fifo_level), 2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("pp_tail_addr11", 32'(bus.mem_addr), 11);
    tick();
    checkOutput("pp_level1", 32'(fifo_level), 1);
    checkOutput("pp_tail_addr12", 32'(bus.mem_addr), 12);
    tick();
    checkOutput("pp_level0", 32'(fifo_level), 0);

    // Clear with pending writes (one pushed alongside clr_start), alternating reads
    mark = wlog.size();
    applyStimulus(1, 4'hF, 1, 13, 24'hD0000D, 0);
    tick();
    applyStimulus(0, 0, 1, 14, 24'hD0000E, 1);
    checkOutput("clr_start_wr_ready", 32'(bus.wr_ready), 1);
    checkOutput("clr_start_head", 32'(bus.mem_addr), 13);
    tick();
    applyStimulus(0, 4'hF, 0, 0, 0, 0);
    checkOutput("drain_busy", 32'(clr_busy), 1);
    checkOutput("drain_wr_ready", 32'(bus.wr_ready), 0);
    checkOutput("drain_level", 32'(fifo_level), 1);
    prev_rq = 1'b0;
    cycles  = 0;
    while (clr_busy && cycles < 100) begin
      rq = cycles[0];
      applyStimulus(rq, 4'hF, 0, 0, 0, 0);
      if (prev_rq) begin
        checkOutput("clr_rd_valid", 32'(bus.rd_valid), 1);
        checkOutput("clr_rd_data", 32'(bus.rd_data), 32'h0010000F);
      end else begin
        checkOutput("clr_rd_idle", 32'(bus.rd_valid), 0);
      end
      prev_rq = rq;
      tick();
      cycles++;
    end
    checkOutput("clr_done", 32'(clr_busy), 0);
    checkOutput("clr_cycles", 32'(cycles), 33);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("clr_last_rd_valid", 32'(bus.rd_valid), 32'(prev_rq));
    checkOutput("clr_wr_ready", 32'(bus.wr_ready), 1);
    n = wlog.size() - mark;
    checkOutput("clr_write_count", 32'(n), 18);
    if (n == 18) begin
      checkOutput("clr_fifo0", 32'(wlog[mark]), 32'({4'd13, 24'hD0000D}));
      checkOutput("clr_fifo1", 32'(wlog[mark + 1]), 32'({4'd14, 24'hD0000E}));
      for (int i = 0; i < 16; i++)
        checkOutput("clr_word", 32'(wlog[mark + 2 + i]), 32'({4'(i), CLR}));
    end

    // Reset in the middle of a clear, then restart from address 0
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("clr2_first_addr", 32'(bus.mem_addr), 0);
    cycles = 0;
    while (!(bus.mem_we && bus.mem_addr == 4'd7) && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput("clr2_reach7", 32'(bus.mem_addr), 7);
    resetn = 1'b0;
    applyStimulus(0, 0, 1, 2, 24'h123456, 0);
    checkOutput("midreset_wr_ready", 32'(bus.wr_ready), 0);
    tick();
    resetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("midreset_busy", 32'(clr_busy), 0);
    checkOutput("midreset_level", 32'(fifo_level), 0);
    checkOutput("midreset_mem_en", 32'(bus.mem_en), 0);

    // Restart; a second clr_start during the clear must be ignored
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("restart_we", 32'(bus.mem_we), 1);
    checkOutput("restart_addr", 32'(bus.mem_addr), 0);
    checkOutput("restart_data", 32'(bus.mem_wdata), 32'(CLR));
    mark   = wlog.size();
    cycles = 0;
    while (clr_busy && cycles < 60) begin
      applyStimulus(0, 0, 0, 0, 0, (cycles == 3));
      tick();
      cycles++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("restart_done", 32'(clr_busy), 0);
    n = wlog.size() - mark;
    checkOutput("restart_count", 32'(n), 16);
    if (n == 16) begin
      for (int i = 0; i < 16; i++)
        checkOutput("restart_addr_seq", 32'(wlog[mark + i].a), 32'(i));
    end
    tick();
    tick();
    checkOutput("after_clr_mem_en", 32'(bus.mem_en), 0);
    checkOutput("after_clr_no_writes", 32'(wlog.size() - mark), 16);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
